// File: rtl/riscv_pipe_stage_reg_pkg.sv
// Shared definitions for the pipelined RV32I inter-stage register:
// core width, default payload widths and the occupancy state encoding.
package riscv_pipe_stage_reg_pkg;

    localparam int XLEN       = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 4 * XLEN;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/riscv_pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module riscv_pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/riscv_pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, flush, optional
// 2-entry skid buffer and a saturating stall-cycle counter.
module riscv_pipe_stage_reg
    import riscv_pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W        = CTRL_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SKID          = 0,
    parameter int REGISTER_INIT = 0,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    pipe_state_e       state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              skid_valid;
    logic              in_xfer, out_xfer;
    logic              main_ld, main_from_skid, skid_ld;

    assign o_valid    = (state != ST_EMPTY);
    assign skid_valid = (state == ST_TWO);
    assign in_xfer    = i_valid & o_ready;
    assign out_xfer   = o_valid & i_ready;
    assign o_ctrl     = o_valid ? main_ctrl : '0;
    assign o_data     = main_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // With SKID=0 the ONE/in/!out arc is unreachable because o_ready
    // requires i_ready whenever the main entry is valid.
    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ST_ONE;
                    main_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = ST_TWO;
                    skid_ld   = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_nxt      = ST_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (i_flush)
            state_nxt = ST_EMPTY;
    end

    // Control is cleared by reset so bubbles never leak write enables;
    // data is only reset when REGISTER_INIT asks for it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            main_ctrl <= '0;
        else if (main_ld)
            main_ctrl <= main_from_skid ? skid_ctrl : i_ctrl;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            if (REGISTER_INIT != 0)
                main_data <= '0;
        end else if (main_ld) begin
            main_data <= main_from_skid ? skid_data : i_data;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            assign o_ready = i_rstn & ~skid_valid;

            always_ff @(posedge i_clk) begin
                if (!i_rstn)
                    skid_ctrl <= '0;
                else if (skid_ld)
                    skid_ctrl <= i_ctrl;
            end

            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    if (REGISTER_INIT != 0)
                        skid_data <= '0;
                end else if (skid_ld) begin
                    skid_data <= i_data;
                end
            end
        end else begin : g_noskid
            assign o_ready   = i_rstn & (~o_valid | i_ready);
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

    riscv_pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .en    (o_valid & ~i_ready),
        .clr   (~i_rstn),
        .count (o_stall_cnt)
    );

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Drives a single-entry and a skid instance with shared stimulus and
// compares both against queue-based reference models every cycle.
module tb_riscv_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 128;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rstn, flush, valid, ready;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    logic          rdy0, vld0, rdy1, vld1;
    logic [CW-1:0] octl0, octl1;
    logic [DW-1:0] odat0, odat1;
    logic [15:0]   cnt0;
    logic [3:0]    cnt1;

    int   total = 0;
    int   bad   = 0;
    ent_t q0[$];
    ent_t q1[$];
    int   mcnt0, mcnt1;
    bit   acc1;

    always #5 clk = ~clk;

    riscv_pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .REGISTER_INIT(0), .CNT_W(16)) u_s0 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(rdy0),
        .i_ctrl(ctrl), .i_data(data), .o_valid(vld0), .i_ready(ready),
        .o_ctrl(octl0), .o_data(odat0), .o_stall_cnt(cnt0));

    riscv_pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .REGISTER_INIT(1), .CNT_W(4)) u_s1 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(rdy1),
        .i_ctrl(ctrl), .i_data(data), .o_valid(vld1), .i_ready(ready),
        .o_ctrl(octl1), .o_data(odat1), .o_stall_cnt(cnt1));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Ready as the block should advertise it, from occupancy alone.
    function automatic bit mrdy0();
        return rstn && (q0.size() == 0 || ready);
    endfunction
    function automatic bit mrdy1();
        return rstn && (q1.size() < 2);
    endfunction

    task automatic tick();
        bit   a0, a1, o0, o1;
        ent_t e;
        #1;
        chk("rdy0", rdy0, mrdy0());
        chk("rdy1", rdy1, mrdy1());
        a0 = valid && mrdy0();
        a1 = valid && mrdy1();
        o0 = (q0.size() != 0) && ready;
        o1 = (q1.size() != 0) && ready;
        e.c = ctrl;
        e.d = data;
        @(posedge clk);
        if (!rstn) begin
            q0.delete(); q1.delete();
            mcnt0 = 0; mcnt1 = 0;
            a1 = 0;
        end else begin
            if (q0.size() != 0 && !ready && mcnt0 < 65535) mcnt0++;
            if (q1.size() != 0 && !ready && mcnt1 < 15) mcnt1++;
            if (o0) void'(q0.pop_front());
            if (o1) void'(q1.pop_front());
            if (flush) begin
                q0.delete(); q1.delete();
                a1 = 0;
            end else begin
                if (a0) q0.push_back(e);
                if (a1) q1.push_back(e);
            end
        end
        acc1 = a1;
        @(negedge clk);
        chk("vld0", vld0, q0.size() != 0);
        chk("vld1", vld1, q1.size() != 0);
        chk("ctl0", octl0, (q0.size() != 0) ? q0[0].c : '0);
        chk("ctl1", octl1, (q1.size() != 0) ? q1[0].c : '0);
        if (q0.size() != 0) chk("dat0", odat0, q0[0].d);
        if (q1.size() != 0) chk("dat1", odat1, q1[0].d);
        chk("cnt0", cnt0, mcnt0);
        chk("cnt1", cnt1, mcnt1);
    endtask

    task automatic drain();
        valid = 0; flush = 0; ready = 1;
        repeat (3) tick();
    endtask

    initial begin
        int idx;
        rstn = 0; flush = 0; valid = 0; ready = 0; ctrl = '0; data = '0;
        mcnt0 = 0; mcnt1 = 0; acc1 = 0;

        // reset, then a single entry
        repeat (2) tick();
        rstn = 1; valid = 1; ctrl = 8'hA5; data = 1; ready = 1;
        tick();
        chk("t1_ctl", octl0, 8'hA5);
        chk("t1_dat", odat0, 1);

        // back-to-back stream
        for (int i = 0; i < 10; i++) begin
            data = i; ctrl = CW'($urandom);
            tick();
        end
        drain();

        // stall fill: source only advances on skid acceptance
        idx = 0; ready = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) ready = 1;
            valid = (idx < 3); data = idx; ctrl = CW'(8'h10 + idx);
            tick();
            if (acc1) idx++;
        end
        chk("t3_all_sent", idx, 3);
        drain();

        // flush while full and stalled
        ready = 0; valid = 1;
        for (int i = 0; i < 2; i++) begin
            data = 100 + i; tick();
        end
        flush = 1; data = 200; tick();
        flush = 0; valid = 0;
        chk("t4_vld1", vld1, 0);
        chk("t4_ctl1", octl1, 0);
        tick();

        // flush with concurrent out-transfer
        ready = 1; valid = 1; data = 300; tick();
        flush = 1; data = 301; tick();
        flush = 0; valid = 0; tick();

        // counter saturation, then reset while full
        ready = 0; valid = 1;
        for (int i = 0; i < 20; i++) begin
            data = 400 + i; tick();
        end
        chk("t6_sat", cnt1, 15);
        rstn = 0; tick();
        chk("t6_rst_vld", vld1, 0);
        chk("t6_rst_cnt", cnt1, 0);
        rstn = 1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            valid = ($urandom % 4) != 0;
            ready = ($urandom % 3) != 0;
            flush = ($urandom % 16) == 0;
            rstn  = ($urandom % 64) != 0;
            ctrl  = CW'($urandom);
            data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_stage_reg.md
Name: riscv_pipe_stage_reg

Overview:
- Generic, parametrised inter-stage register for the pipelined RV32I core.
- Replaces the fixed per-stage flop banks (ID/EX, EX/MEM, MEM/WB) with one block.
- Adds a valid/ready handshake, stall, flush (bubble insertion), an optional 2-entry skid buffer and a saturating stall-cycle counter.
- Payload is split into control bits, zeroed on bubbles, and data bits, which are never gated.

Parameters:
- CTRL_W, 8: control payload width (RegWrite, MemWrite, ResultSrc, MUX_sel, …).
- DATA_W, 4*`XLEN: data payload width (ALU result, write data, PC+imm, imm, PC+4, …).
- SKID, 0: 0 = single entry, combinational ready; 1 = two entries, registered ready.
- REGISTER_INIT, 0: 1 = data registers reset to 0; 0 = data registers not reset (control and valid always reset).
- CNT_W, 16: stall counter width.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rstn, input, 1: synchronous active-low reset.
- i_flush, input, 1: kill all held and incoming entries at this edge.
- i_valid, input, 1: upstream entry valid.
- o_ready, output, 1: stage can accept this cycle.
- i_ctrl, input, CTRL_W: upstream control payload.
- i_data, input, DATA_W: upstream data payload.
- o_valid, output, 1: downstream entry valid.
- i_ready, input, 1: downstream accepts.
- o_ctrl, output, CTRL_W: control out; forced to 0 when o_valid=0.
- o_data, output, DATA_W: data out; ungated.
- o_stall_cnt, output, CNT_W: cycles with o_valid=1 and i_ready=0, saturating.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rstn. All state changes occur on the rising edge.
- Transfers:
  - In-transfer = i_valid & o_ready.
  - Out-transfer = o_valid & i_ready.
  - Latency is 1 cycle from in-transfer to o_valid when the stage is empty.
- Reset (i_rstn=0 at an edge):
  - All valid bits cleared, so o_valid=0 and o_ctrl=0.
  - o_stall_cnt=0.
  - Data registers cleared only if REGISTER_INIT=1.
  - o_ready is forced to 0 while i_rstn=0 and returns to 1 on the first cycle after reset.
  - Reset mid-operation discards all entries without completing an out-transfer.
- States: EMPTY, ONE (main entry valid), TWO (main and skid entries valid; exists only when SKID=1).
- SKID=0:
  - o_ready = !o_valid | i_ready (combinational).
  - Main entry loads on in-transfer.
  - Main entry empties on out-transfer without a simultaneous in-transfer.
  - Holds otherwise (stall).
- SKID=1, o_ready = !skid_valid (registered, no comb path from i_ready):
  - EMPTY, in → ONE.
  - ONE, in & out → ONE (new entry in main).
  - ONE, in & !out → TWO (new entry in skid).
  - ONE, !in & out → EMPTY.
  - TWO, out → ONE (skid moves to main).
  - TWO, !out → TWO.
  - Ordering is preserved: main is always older than skid.
- Flush (i_flush=1 at an edge, reset having priority over it):
  - All valid bits are 0 after the edge. Any in-transfer in that cycle is dropped.
  - An out-transfer in the same cycle still completes normally.
  - Data registers may load or hold; they are don't-care while invalid.
  - o_stall_cnt is unaffected.
- Simultaneous in-transfer and out-transfer when full (SKID=0, ONE):
  - The entry is replaced; no bubble is inserted.
- o_ctrl:
  - o_ctrl = o_valid ? main_ctrl : 0.
  - A bubble can therefore never assert RegWrite or MemWrite downstream.
- Stall counter:
  - Increments when o_valid & !i_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.

Decomposition:
- CTRL_W and DATA_W field layouts go in riscv_configs.v (XLEN already lives there).
- State encodings go in pipe_ctrl.v: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- One natural sub-module, riscv_pipe_sat_counter (parameter W; ports: enable, synchronous clear, count), used for o_stall_cnt.
- The skid path is inline, under a generate on SKID.

Test Plan:
1. Reset and fill, SKID=0:
   - Stimulus: hold i_rstn=0 for 2 cycles, release; then i_valid=1, i_ctrl=8'hA5, i_data=1, i_ready=1.
   - Response: during reset o_ready=0 and o_valid=0. Next cycle o_valid=1, o_ctrl=8'hA5, o_data=1.
2. Back-to-back streaming, SKID=0 and SKID=1:
   - Stimulus: 10 consecutive entries with i_data=0..9, i_ready held at 1.
   - Response: o_data=0..9 on consecutive cycles, o_ready continuously 1.
3. Stall fill, SKID=1:
   - Stimulus: i_ready=0, send 3 entries (0, 1, 2).
   - Response: o_ready drops after the 2nd entry; entry 2 is held upstream. Raising i_ready yields 0, 1, 2 in order. o_stall_cnt equals the number of stalled cycles with o_valid=1.
4. Flush in TWO with i_ready=0:
   - Stimulus: i_flush=1 for 1 cycle while i_valid=1.
   - Response: next cycle o_valid=0, o_ctrl=0; the incoming entry is lost; o_ready=1.
5. Flush with a concurrent out-transfer (i_ready=1):
   - Response: the current o_data is consumed once, then o_valid=0.
6. Counter saturation and reset mid-operation:
   - Stimulus: CNT_W=4, 20 stall cycles; then pulse i_rstn=0 while in TWO.
   - Response: o_stall_cnt reaches 15 and holds there. After the reset edge, o_valid=0 and o_stall_cnt=0.
